// File: rtl/block_check_pkg.sv
// Shared types and constants for the begin/end nesting checker
// and its two-requester scheduler.
package block_check_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_FLUSH,
      S_RESULT
   } sched_state_t;

   typedef enum logic [3:0] {
      K_START,
      K_SKIP,
      K_B,
      K_BE,
      K_BEG,
      K_BEGI,
      K_BEGIN,
      K_E,
      K_EN,
      K_END
   } kw_state_t;

   localparam logic [7:0] CH_SPACE = 8'd32;
   localparam logic [7:0] CH_UA    = 8'd65;
   localparam logic [7:0] CH_UZ    = 8'd90;
   localparam logic [7:0] CH_LA    = 8'd97;
   localparam logic [7:0] CH_LZ    = 8'd122;
   localparam logic [7:0] CH_B     = 8'd98;
   localparam logic [7:0] CH_D     = 8'd100;
   localparam logic [7:0] CH_E     = 8'd101;
   localparam logic [7:0] CH_G     = 8'd103;
   localparam logic [7:0] CH_I     = 8'd105;
   localparam logic [7:0] CH_N     = 8'd110;

   localparam int LEN_W_DEF = 16;

   function automatic logic is_upper(input logic [7:0] c);
      return (c >= CH_UA) && (c <= CH_UZ);
   endfunction

   function automatic logic is_alpha(input logic [7:0] c);
      return is_upper(c) || ((c >= CH_LA) && (c <= CH_LZ));
   endfunction

   function automatic logic [7:0] to_lower(input logic [7:0] c);
      return is_upper(c) ? (c | CH_SPACE) : c;
   endfunction

endpackage

// File: rtl/block_check_core.sv
// Case-insensitive begin/end nesting checker, one character per ce.
// ok reflects the verdict as if the stream ended right now.
module block_check_core
   import block_check_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       ce,
   input  logic [7:0] in,
   output logic       ok
);

   kw_state_t   kw;
   kw_state_t   kw_nxt;
   logic [31:0] depth;
   logic        err;
   logic [7:0]  c;
   logic        alpha;

   always_comb begin
      c      = to_lower(in);
      alpha  = is_alpha(in);
      kw_nxt = K_SKIP;
      case (kw)
         K_START: begin
            if (c == CH_B)      kw_nxt = K_B;
            else if (c == CH_E) kw_nxt = K_E;
         end
         K_B:    if (c == CH_E) kw_nxt = K_BE;
         K_BE:   if (c == CH_G) kw_nxt = K_BEG;
         K_BEG:  if (c == CH_I) kw_nxt = K_BEGI;
         K_BEGI: if (c == CH_N) kw_nxt = K_BEGIN;
         K_E:    if (c == CH_N) kw_nxt = K_EN;
         K_EN:   if (c == CH_D) kw_nxt = K_END;
         default: kw_nxt = K_SKIP;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kw    <= K_START;
         depth <= '0;
         err   <= 1'b0;
      end else if (clr) begin
         kw    <= K_START;
         depth <= '0;
         err   <= 1'b0;
      end else if (ce) begin
         if (alpha) begin
            kw <= kw_nxt;
         end else begin
            kw <= K_START;
            if (kw == K_BEGIN) begin
               depth <= depth + 32'd1;
            end else if (kw == K_END) begin
               if (depth == '0) err   <= 1'b1;
               else             depth <= depth - 32'd1;
            end
         end
      end
   end

   // A pending complete keyword is resolved as if terminated here.
   always_comb begin
      case (kw)
         K_BEGIN: ok = 1'b0;
         K_END:   ok = !err && (depth == 32'd1);
         default: ok = !err && (depth == '0);
      endcase
   end

endmodule

// File: rtl/block_check_sched.sv
// Program-granular arbiter feeding one nesting checker from two
// character streams and returning one registered verdict per program.
module block_check_sched
   import block_check_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s0_valid,
   input  logic [7:0]       s0_data,
   input  logic             s0_last,
   output logic             s0_ready,
   input  logic             s1_valid,
   input  logic [7:0]       s1_data,
   input  logic             s1_last,
   output logic             s1_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_ok,
   output logic             res_src,
   output logic [LEN_W-1:0] res_len,
   output logic             res_sat
);

   sched_state_t     state;
   logic             grant;
   logic             prio;
   logic [LEN_W-1:0] cnt;
   logic             sat;
   logic             g_valid;
   logic             g_last;
   logic [7:0]       g_data;
   logic             beat;
   logic             core_clr;
   logic             core_ok;

   assign g_valid  = grant ? s1_valid : s0_valid;
   assign g_last   = grant ? s1_last  : s0_last;
   assign g_data   = grant ? s1_data  : s0_data;
   assign s0_ready = (state == S_STREAM) && !grant;
   assign s1_ready = (state == S_STREAM) && grant;
   assign beat     = (state == S_STREAM) && g_valid;
   assign core_clr = (state == S_CLEAR);

   block_check_core u_core (
      .clk   (clk),
      .reset (reset),
      .clr   (core_clr),
      .ce    (beat),
      .in    (g_data),
      .ok    (core_ok)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         grant     <= 1'b0;
         prio      <= 1'b0;
         cnt       <= '0;
         sat       <= 1'b0;
         res_valid <= 1'b0;
         res_ok    <= 1'b0;
         res_src   <= 1'b0;
         res_len   <= '0;
         res_sat   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (s0_valid || s1_valid) begin
                  grant <= prio ? s1_valid : !s0_valid;
                  state <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               cnt   <= '0;
               sat   <= 1'b0;
               state <= S_STREAM;
            end
            S_STREAM: begin
               if (beat) begin
                  if (&cnt) sat <= 1'b1;
                  else      cnt <= cnt + 1'b1;
                  if (g_last) state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               res_ok    <= core_ok;
               res_src   <= grant;
               res_len   <= cnt;
               res_sat   <= sat;
               res_valid <= 1'b1;
               state     <= S_RESULT;
            end
            S_RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  prio      <= ~grant;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_block_check_sched.sv
// Randomized bench for block_check_sched with a word-level
// reference model and per-source expected-verdict queues.
module tb_block_check_sched;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        s0_valid = 1'b0, s1_valid = 1'b0;
   logic [7:0]  s0_data = 8'd0, s1_data = 8'd0;
   logic        s0_last = 1'b0, s1_last = 1'b0;
   logic        res_ready = 1'b0;
   logic        s0_ready, s1_ready, res_valid, res_ok, res_src, res_sat;
   logic [15:0] res_len;
   logic        s0_ready_4, s1_ready_4, res_valid_4, res_ok_4, res_src_4;
   logic        res_sat_4;
   logic [3:0]  res_len_4;

   int errors = 0;
   int checks = 0;
   int rr_mode = 1;
   int n_exp = 0;

   typedef struct {bit ok; int len;} exp_t;
   typedef struct {bit ok; bit src; int len; bit sat; int len4; bit sat4;} res_t;
   exp_t q0[$];
   exp_t q1[$];
   res_t log_q[$];

   block_check_sched #(.LEN_W(16)) dut (
      .clk(clk), .reset(reset),
      .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last),
      .s0_ready(s0_ready),
      .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last),
      .s1_ready(s1_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_ok(res_ok),
      .res_src(res_src), .res_len(res_len), .res_sat(res_sat)
   );

   block_check_sched #(.LEN_W(4)) dut4 (
      .clk(clk), .reset(reset),
      .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last),
      .s0_ready(s0_ready_4),
      .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last),
      .s1_ready(s1_ready_4),
      .res_valid(res_valid_4), .res_ready(res_ready), .res_ok(res_ok_4),
      .res_src(res_src_4), .res_len(res_len_4), .res_sat(res_sat_4)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Word-level reference: split on non-letters, count keywords.
   function automatic bit model_ok(input string p);
      int depth = 0;
      bit err = 0;
      int ws = 0;
      string w;
      for (int i = 0; i <= p.len(); i++) begin
         byte c = (i < p.len()) ? p[i] : 8'd32;
         bit letter = (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
         if (!letter) begin
            if (i > ws) begin
               w = p.substr(ws, i - 1);
               w = w.tolower();
               if (w == "begin") depth++;
               else if (w == "end") begin
                  if (depth == 0) err = 1;
                  else depth--;
               end
            end
            ws = i + 1;
         end
      end
      return !err && depth == 0;
   endfunction

   function automatic string pick_word(input int k);
      case (k)
         0: return "begin";  1: return "BEGIN";  2: return "Begin";
         3: return "end";    4: return "END";    5: return "End";
         6: return "beginx"; 7: return "endy";   8: return "be";
         9: return "en";     10: return "x";     default: return "begi";
      endcase
   endfunction

   function automatic string pick_delim(input int k);
      case (k)
         0: return " ";
         1: return ",";
         2: return "1";
         default: return ".";
      endcase
   endfunction

   function automatic string rand_prog();
      string p = "";
      int nw = $urandom_range(1, 5);
      for (int j = 0; j < nw; j++) begin
         p = {p, pick_word($urandom_range(0, 11))};
         if (j < nw - 1 || $urandom_range(0, 1) == 1)
            p = {p, pick_delim($urandom_range(0, 3))};
      end
      return p;
   endfunction

   function automatic bit rdy(input bit src);
      return src ? s1_ready : s0_ready;
   endfunction

   task automatic drive(input bit src, input bit v, input byte d, input bit l);
      if (src) begin
         s1_valid = v; s1_data = d; s1_last = l;
      end else begin
         s0_valid = v; s0_data = d; s0_last = l;
      end
   endtask

   task automatic send(input bit src, input string p, input int gap_at = -1,
                       input int gap_len = 0, input bit abort = 0);
      exp_t e;
      int b;
      if (!abort) begin
         e.ok = model_ok(p);
         e.len = p.len();
         if (src) q1.push_back(e);
         else     q0.push_back(e);
         n_exp++;
      end
      for (int i = 0; i < p.len(); i++) begin
         if (i == gap_at) begin
            drive(src, 0, 8'd0, 0);
            repeat (gap_len) @(posedge clk);
            #1;
         end
         drive(src, 1, p[i], !abort && i == p.len() - 1);
         b = 0;
         @(negedge clk);
         while (!rdy(src) && b < 600) begin
            b++;
            @(negedge clk);
         end
         if (!rdy(src)) begin
            errors++;
            checks++;
            $display("FAIL ready_timeout src=%0d: got ready=0 want 1", src);
            drive(src, 0, 8'd0, 0);
            return;
         end
         @(posedge clk);
         #1;
      end
      if (!abort) drive(src, 0, 8'd0, 0);
   endtask

   task automatic wait_results(input int n);
      int b = 0;
      while (log_q.size() < n && b < 3000) begin
         b++;
         @(negedge clk);
      end
      check("wait_results", log_q.size(), n);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rr_mode)
            0: res_ready = ($urandom_range(0, 1) == 1);
            1: res_ready = 1'b1;
            default: res_ready = 1'b0;
         endcase
      end
   end

   // Cycle compare: handshake verdicts, hold stability, ready exclusion.
   initial begin
      bit hold = 0;
      logic [19:0] prev = '0;
      exp_t e;
      res_t r;
      forever begin
         @(negedge clk);
         if (reset) begin
            hold = 0;
         end else begin
            check("ready_excl", s0_ready & s1_ready, 0);
            if (hold) begin
               check("hold_stable", {res_valid, res_ok, res_src, res_len, res_sat}, prev);
               check("hold_ready", {s0_ready, s1_ready}, 0);
            end
            if (res_valid && res_ready) begin
               if ((res_src ? q1.size() : q0.size()) == 0) begin
                  errors++;
                  checks++;
                  $display("FAIL unexpected_result src=%0d: got result want none", res_src);
               end else begin
                  e = res_src ? q1.pop_front() : q0.pop_front();
                  check("res_ok", res_ok, e.ok);
                  check("res_len", res_len, e.len > 65535 ? 65535 : e.len);
                  check("res_sat", res_sat, e.len > 65535);
                  check("res4_valid", res_valid_4, 1);
                  check("res4_ok", res_ok_4, e.ok);
                  check("res4_len", res_len_4, e.len > 15 ? 15 : e.len);
                  check("res4_sat", res_sat_4, e.len > 15);
               end
               r.ok = res_ok; r.src = res_src; r.len = res_len; r.sat = res_sat;
               r.len4 = res_len_4; r.sat4 = res_sat_4;
               log_q.push_back(r);
            end
            hold = res_valid && !res_ready;
            prev = {res_valid, res_ok, res_src, res_len, res_sat};
         end
      end
   end

   initial begin
      string pa, pb;
      int b;
      repeat (3) @(posedge clk);
      #1;
      check("reset_out", {s0_ready, s1_ready, res_valid, res_ok, res_src, res_len, res_sat}, 0);
      check("reset_out4", {s0_ready_4, s1_ready_4, res_valid_4, res_ok_4, res_src_4,
                           res_len_4, res_sat_4}, 0);
      reset = 1'b0;

      check("model_pin1", model_ok("End Begin"), 0);
      check("model_pin2", model_ok("beginx endy"), 1);
      check("model_pin3", model_ok("BEGIN begin end,End"), 1);
      check("model_pin4", model_ok("begin"), 0);

      fork
         send(0, "begin end");
         send(1, "End Begin");
      join
      wait_results(2);
      check("tie1_src0", log_q[0].src, 0);
      check("tie1_ok0", log_q[0].ok, 1);
      check("tie1_len0", log_q[0].len, 9);
      check("tie1_sat0", log_q[0].sat, 0);
      check("tie1_src1", log_q[1].src, 1);
      check("tie1_ok1", log_q[1].ok, 0);
      check("tie1_len1", log_q[1].len, 9);

      fork
         send(0, "beginx endy");
         send(1, "x");
      join
      wait_results(4);
      check("tie2_src0", log_q[2].src, 0);
      check("tie2_ok0", log_q[2].ok, 1);
      check("tie2_src1", log_q[3].src, 1);

      send(0, "begin");
      wait_results(5);
      check("open_begin_ok", log_q[4].ok, 0);
      check("open_begin_len", log_q[4].len, 5);

      send(0, "begin end", 2, 5);
      wait_results(6);
      check("gap_ok", log_q[5].ok, 1);
      check("gap_len", log_q[5].len, 9);

      rr_mode = 2;
      send(1, "end");
      b = 0;
      while (!res_valid && b < 100) begin
         b++;
         @(negedge clk);
      end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_lit", {res_valid, res_src, s0_ready, s1_ready}, 4'b1100);
      end
      rr_mode = 1;
      wait_results(7);
      check("hold_res_ok", log_q[6].ok, 0);

      q0.push_back('{ok: 1'b1, len: 1});
      n_exp++;
      @(posedge clk);
      #1;
      drive(0, 1, "x", 1);
      @(posedge clk);
      @(negedge clk);
      check("lat_clear_ready", s0_ready, 0);
      @(negedge clk);
      check("lat_stream_ready", s0_ready, 1);
      @(posedge clk);
      #1;
      drive(0, 0, 8'd0, 0);
      @(negedge clk);
      check("lat_flush_valid", res_valid, 0);
      @(negedge clk);
      check("lat_res_valid", res_valid, 1);
      @(negedge clk);
      check("lat_one_cycle", res_valid, 0);
      wait_results(8);
      check("single_len", log_q[7].len, 1);

      send(0, "begin", -1, 0, 1);
      reset = 1'b1;
      #1;
      check("abort_out", {s0_ready, s1_ready, res_valid, res_ok, res_src, res_len, res_sat}, 0);
      check("abort_out4", {s0_ready_4, s1_ready_4, res_valid_4, res_ok_4, res_src_4,
                           res_len_4, res_sat_4}, 0);
      drive(0, 0, 8'd0, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      send(0, "end");
      send(0, "x");
      wait_results(10);
      check("post_abort_end", log_q[8].ok, 0);
      check("post_abort_x", log_q[9].ok, 1);

      send(1, "begin end abcdefgh");
      wait_results(11);
      check("sat_len16", log_q[10].len, 18);
      check("sat_sat16", log_q[10].sat, 0);
      check("sat_len4", log_q[10].len4, 15);
      check("sat_sat4", log_q[10].sat4, 1);
      check("sat_ok", log_q[10].ok, 1);

      rr_mode = 0;
      for (int k = 0; k < 40; k++) begin
         pa = rand_prog();
         pb = rand_prog();
         if ($urandom_range(0, 3) == 0) begin
            fork
               send(0, pa);
               send(1, pb);
            join
         end else if ($urandom_range(0, 1) == 1) begin
            send($urandom_range(0, 1), pa, $urandom_range(0, pa.len() - 1),
                 $urandom_range(1, 4));
         end else begin
            send($urandom_range(0, 1), pa);
         end
      end
      wait_results(n_exp);
      check("queues_drained", q0.size() + q1.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/block_check_sched.md
# block_check_sched

Scheduler that shares one begin/end nesting checker between two character-stream requesters. It arbitrates at program granularity, clears the checker before each program, and feeds the granted stream beat-by-beat under a valid/ready handshake. It returns one registered verdict per program (balanced or not, source, length) on a result handshake. It sits between the text sources and the downstream consumer of check results.

## Interface
Parameters:
- LEN_W, 16, width of the per-program beat counter and of res_len.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- s0_valid / s1_valid  in  1  requester beat valid.
- s0_data / s1_data  in  8  ASCII character.
- s0_last / s1_last  in  1  marks the final character of the program.
- s0_ready / s1_ready  out  1  beat accepted when valid & ready.
- res_valid  out  1  verdict available.
- res_ready  in  1  consumer accepts the verdict.
- res_ok  out  1  1 = balanced program, 0 = unbalanced.
- res_src  out  1  requester that produced the verdict.
- res_len  out  LEN_W  accepted beat count, saturating at 2^LEN_W-1.
- res_sat  out  1  res_len saturated.

## Operation
- FSM states: IDLE, CLEAR, STREAM, FLUSH, RESULT.
- IDLE: if any sN_valid, grant the priority requester if valid, else the other one. Latch the grant and go to CLEAR. Otherwise stay in IDLE.
- CLEAR: one cycle. Pulse the core's synchronous clear, zero the length counter, then go to STREAM.
- STREAM:
  - The granted sN_ready is 1. The other ready and all readies in other states are 0.
  - Each accepted beat drives core ce=1 with that data and increments the length counter, saturating and setting a sticky sat bit.
  - ce=0 on cycles without a beat; the core state is frozen, so valid gaps never split words.
  - An accepted beat with last=1 moves the FSM to FLUSH.
- FLUSH: capture core verdict, length, sat and grant into the res_* registers. Set res_valid and go to RESULT.
- RESULT: hold every res_* output stable until res_valid & res_ready. Then clear res_valid, set priority to the non-served requester, and go to IDLE.
- Core semantics (applied only on ce):
  - Letters are case-insensitive. A–Z and a–z form words; every other byte is a delimiter.
  - A word exactly "begin" increments depth. A word exactly "end" decrements depth, or sets a sticky error when depth is 0.
  - A word is classified when it terminates: on a delimiter or at end of program. Prefixes and extensions ("beginx", "endy", "be") count as nothing.
  - Depth is 32 bits.
  - Verdict: ok = !error && depth==0, evaluated after the last beat, with end of program acting as a terminator.

## Timing
- Reset values: state IDLE, priority requester 0, s0_ready=s1_ready=0, res_valid=0, res_ok=0, res_src=0, res_len=0, res_sat=0, core cleared.
- Reset asserted in any state aborts the program immediately. No partial verdict is produced and no checker state carries into the next program.
- Valid seen in IDLE at edge t: CLEAR during t..t+1, ready=1 from edge t+1.
- Last beat accepted at edge t: FLUSH during t..t+1, res_valid=1 from edge t+1.
- When res_ready is high in the first RESULT cycle, res_valid is high for exactly one cycle. IDLE always spends at least one cycle before the next grant.
- Both requesters valid in IDLE at once: priority wins and the other waits with ready=0. Its data and last must stay stable (source obligation).
- A single-beat program (valid & last on the first beat) is legal: res_len=1.
- No bypass paths. All outputs are registered or decoded directly from the state register.

## Structure
- Shared package block_check_pkg:
  - FSM state typedef.
  - Character constants: space 8'd32, 'A' 8'd65, 'Z' 8'd90, 'a' 8'd97, 'z' 8'd122, 'b', 'd', 'e', 'g', 'i', 'n'.
  - Default LEN_W.
- Sub-module block_check_core: nesting checker with clk, reset, clr (sync), ce, in[7:0] and ok outputs. It has a 10-state keyword FSM, a 32-bit depth counter and a sticky error bit.
- The top level holds the arbiter/sequencer FSM, the priority bit, the length counter and the result registers.

## Test plan
- s0 sends "begin end" with last on 'd' → res_valid, res_ok=1, res_src=0, res_len=9, res_sat=0.
- s1 sends "End Begin" → res_ok=0 (sticky error despite the later begin), res_src=1, res_len=9.
- s0 "beginx endy" → res_ok=1. Then s0 "begin" with last on 'n' → res_ok=0 (depth 1 at end of program).
- Both valid in the first IDLE cycle after reset:
  - s0 is served first and s1_ready stays 0 throughout.
  - s1 is served next.
  - On the next tie s0 wins again (priority toggles to the non-served requester).
- s0 sends "be", drops valid for 5 cycles, then sends "gin end" → res_ok=1 and res_len=9.
- Ready and reset behaviour:
  - res_ready held low for 10 cycles → res_* stable and both readies 0.
  - Reset asserted mid-STREAM of "begin" → all outputs return to reset values.
  - A following program "end" → res_ok=0, and "x" → res_ok=1 (no carried depth).
  - With LEN_W=4, an 18-beat program → res_len=15, res_sat=1.
